// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer widths and Gray/binary helpers for the async FIFO controllers
package fifo_pkg;
  localparam int FIFO_AW = 5;
  localparam int FIFO_DEPTH = 2**FIFO_AW;
  typedef logic [FIFO_AW:0] ptr_t;
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) bin[i] = bin[i+1] ^ gray[i];
    return bin;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a Gray-coded pointer crossing clock domains
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q1_q, q2_q;
  // back-to-back stages with nothing in between so metastability can settle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q1_q <= '0;
      q2_q <= '0;
    end else begin
      q1_q <= d_i;
      q2_q <= q1_q;
    end
  assign q_o = q2_q;
endmodule

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: write-side pointer, full/almost-full, level and overflow for the async FIFO
module wptr_full_ctrl import fifo_pkg::*; #(
  parameter int ADDR_WIDTH = FIFO_AW,
  parameter int AF_MARGIN  = 4
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  wen,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);
  logic [ADDR_WIDTH:0] wbin_q, wbin_d, wptr_q, wptr_d, wlevel_q, wlevel_d, rq2, rbin;
  logic wfull_q, wfull_d, waf_q, waf_d, wovf_q, wovf_d;
  sync_2ff #(.W(PW)) u_sync (.clk(wclk), .rst(wrst), .d_i(rptr), .q_o(rq2));
  assign wen = winc & ~wfull_q & ~wrst;
  // next pointer and status; full when write Gray equals read Gray with top two bits flipped
  always_comb begin
    rbin     = PW'(gray2bin(32'(rq2)));
    wbin_d   = wbin_q + PW'(wen);
    wptr_d   = PW'(bin2gray(32'(wbin_d)));
    wlevel_d = wbin_d - rbin;
    wfull_d  = wptr_d == (rq2 ^ FULL_MASK);
    waf_d    = wlevel_d >= AF_LEVEL;
    wovf_d   = winc & wfull_q;
  end
  // all write-side state registers
  always_ff @(posedge wclk or posedge wrst)
    if (wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      waf_q    <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      waf_q    <= waf_d;
      wovf_q   <= wovf_d;
    end
  assign waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = waf_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = wovf_q;
endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb_wptr_full_ctrl: scoreboard bench for the write-side FIFO controller
module tb_wptr_full_ctrl;
  import fifo_pkg::*;
  localparam int AW = 5;
  localparam int DEPTH = 32;
  localparam int AFM = 4;
  logic wclk = 1'b0;
  logic wrst = 1'b1;
  logic winc = 1'b0;
  ptr_t rptr = '0;
  logic [AW-1:0] waddr;
  logic [AW:0] wptr, wlevel;
  logic wen, wfull, walmost_full, woverflow;
  typedef struct {
    logic wen;
    int   waddr;
    int   wptr;
    logic wfull;
    logic waf;
    int   wlevel;
    logic wovf;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int w = 0, r = 0, rs1 = 0, rs2 = 0;
  logic m_full = 1'b0;

  always #5 wclk = ~wclk;

  wptr_full_ctrl #(.ADDR_WIDTH(AW), .AF_MARGIN(AFM)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .rptr(rptr), .waddr(waddr), .wen(wen),
    .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
  );

  function automatic int g6(input int v);
    int b;
    b = v % 64;
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic step(input logic inc, input int rr);
    exp_t e;
    int lvl;
    @(negedge wclk);
    winc = inc;
    r = rr;
    rptr = ptr_t'(g6(rr));
    e.wen = inc && !m_full;
    e.waddr = w % DEPTH;
    e.wovf = inc && m_full;
    if (e.wen) w++;
    lvl = w - rs2;
    e.wlevel = lvl;
    e.wfull = (lvl == DEPTH);
    e.waf = (lvl >= DEPTH - AFM);
    e.wptr = g6(w);
    m_full = e.wfull;
    rs2 = rs1;
    rs1 = rr;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge wclk);
    winc = 1'b0;
    @(posedge wclk);
    #1;
    winc = 1'b1;
    wrst = 1'b1;
    #1;
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_wen", 32'(wen), 0);
    chk("rst_wptr", 32'(wptr), 0);
    chk("rst_wfull", 32'(wfull), 0);
    chk("rst_waf", 32'(walmost_full), 0);
    chk("rst_wlevel", 32'(wlevel), 0);
    chk("rst_wovf", 32'(woverflow), 0);
    #2;
    wrst = 1'b0;
    winc = 1'b0;
    rptr = '0;
    w = 0; r = 0; rs1 = 0; rs2 = 0;
    m_full = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge wclk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wen", 32'(wen), 32'(e.wen));
        if (e.wen) chk("waddr", 32'(waddr), e.waddr);
        @(posedge wclk);
        #1;
        chk("wptr", 32'(wptr), e.wptr);
        chk("wfull", 32'(wfull), 32'(e.wfull));
        chk("walmost_full", 32'(walmost_full), 32'(e.waf));
        chk("wlevel", 32'(wlevel), e.wlevel);
        chk("woverflow", 32'(woverflow), 32'(e.wovf));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    for (int i = 0; i < 33; i++) step(1'b1, 0);
    step(1'b0, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 8);
    do_reset();
    for (int i = 0; i < 70; i++) step(1'b1, (w > 4) ? w - 4 : 0);
    do_reset();
    for (int i = 0; i < 31; i++) step(1'b1, 0);
    step(1'b0, 0);
    step(1'b0, 0);
    step(1'b1, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1);
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 0);
    do_reset();
    step(1'b1, 0);
    step(1'b0, 0);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int nr;
      nr = r;
      if (r < w && $urandom_range(0, 9) < 4) nr = r + 1;
      step(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, nr);
    end
    step(1'b0, r);
    repeat (3) @(posedge wclk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wptr_full_ctrl.md
Name: wptr_full_ctrl

Overview:
- Write-side pointer and full-flag controller for the async FIFO, in the wclk domain.
- Directly upstream of the dual-port RAM: generates its write address and write enable from the producer's push requests.
- Synchronises the Gray-coded read pointer into wclk and exports the Gray-coded write pointer to the read-side controller.
- Provides full, almost-full, fill-level and overflow status to the producer.

Parameters:
- ADDR_WIDTH, 5, RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits (ADDR_WIDTH >= 1).
- AF_MARGIN, 4, walmost_full asserts when level >= DEPTH - AF_MARGIN (1 <= AF_MARGIN <= DEPTH).

Ports:
- wclk, input, 1: write-domain clock; all state updates on rising edge.
- wrst, input, 1: reset, asynchronous, active-high.
- winc, input, 1: producer push request for the current cycle.
- rptr, input, ADDR_WIDTH+1: Gray-coded read pointer, from the rclk domain (asynchronous to wclk).
- waddr, output, ADDR_WIDTH: RAM write address.
- wen, output, 1: RAM write enable.
- wptr, output, ADDR_WIDTH+1: Gray-coded write pointer, registered, to the read domain.
- wfull, output, 1: FIFO full, registered.
- walmost_full, output, 1: level at or above the almost-full threshold, registered.
- wlevel, output, ADDR_WIDTH+1: conservative fill level 0..DEPTH, registered.
- woverflow, output, 1: one-cycle pulse when a push is rejected, registered.

Behaviour:
- Clock and reset: one clock (wclk); reset wrst is asynchronous, active-high.
- Reset values: wbin, wptr, rq1, rq2, wfull, walmost_full, wlevel and woverflow are all 0. This gives waddr=0 and wen=0.
- Reset mid-operation: all state clears immediately, without waiting for a clock edge. The read domain must be reset in the same event; otherwise the pointers are inconsistent.
- Synchroniser:
  - rptr passes through two flops: rq1 <= rptr, then rq2 <= rq1.
  - No logic sits between the two stages.
  - A change on rptr is visible in rq2 after the 2nd wclk edge.
- Push acceptance:
  - wen = winc & ~wfull, combinational; it is the only combinational output.
  - waddr = wbin[ADDR_WIDTH-1:0], taken straight from the register.
  - The RAM captures data on the same edge on which the pointer advances.
- Next-pointer computation:
  - wbin_next = wbin + wen, modulo 2**(ADDR_WIDTH+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - Every edge: wbin <= wbin_next and wptr <= wgray_next.
  - wptr changes by exactly one bit per accepted push, including the wrap from 2**(ADDR_WIDTH+1)-1 to 0.
- Full flag:
  - wfull <= (wgray_next == {~rq2[ADDR_WIDTH:ADDR_WIDTH-1], rq2[ADDR_WIDTH-2:0]}).
  - For ADDR_WIDTH=1, both bits of rq2 are inverted.
  - wfull rises on the same edge that accepts the DEPTH-th outstanding write.
  - wfull falls on the 3rd edge after rptr advances: 2 synchroniser edges plus 1 register edge.
- Level:
  - rbin = Gray-to-binary of rq2.
  - wlevel <= wbin_next - rbin, computed in ADDR_WIDTH+1 bits and taken modulo.
  - The level is pessimistic: it never under-reports occupancy.
- Almost-full: walmost_full <= ((wbin_next - rbin) >= DEPTH - AF_MARGIN).
- Overflow: woverflow <= winc & wfull.
  - A rejected push leaves wbin and wptr unchanged and keeps wen low.
- Simultaneous push and rptr advance:
  - The push is evaluated against the current wfull.
  - The new rptr affects wfull only after synchronisation.
  - The flag is never released early.
- Stable rptr: with rptr stable and no pushes, all outputs hold their values.

Decomposition:
- Shared package fifo_pkg holds:
  - function bin2gray(bin) returning ADDR_WIDTH+1 bits;
  - function gray2bin(gray), an XOR prefix from the MSB;
  - localparam-derived DEPTH;
  - a shared `ptr_t` width convention for both the read-side and write-side controllers.
- One sub-module, sync_2ff: a parameterised-width two-flop synchroniser with clk and asynchronous active-high rst. It is reused by the read-side controller for wptr.

Test Plan:
All scenarios use ADDR_WIDTH=5 and AF_MARGIN=4.
1. Reset: assert wrst asynchronously between clock edges with winc=1 -> waddr=0, wen=0, wptr=0, wfull=0, walmost_full=0, wlevel=0 immediately.
2. Fill with rptr=0: 32 back-to-back pushes.
   - waddr steps 0..31 and wen is high for 32 cycles.
   - walmost_full rises on the edge of the 28th push.
   - wfull rises on the edge of the 32nd push, with wlevel=32 and wptr=6'b110000.
   - A 33rd winc gives wen=0, a woverflow pulse of one cycle, and wptr unchanged.
3. Drain release: FIFO full; set rptr=bin2gray(8)=6'b001100 and hold.
   - wfull stays 1 for 2 edges and goes 0 on the 3rd edge.
   - On that same edge wlevel=24 and walmost_full=0.
4. Gray wrap: rptr tracks wptr with a lag of 4 writes; issue 70 pushes.
   - wptr changes exactly one bit per push.
   - wptr passes 6'b100000 (Gray of 63) then 0.
   - waddr wraps 31->0 twice.
   - wfull is never asserted.
5. Simultaneous events: FIFO at level 31; push and rptr advance by 1 in the same cycle.
   - The push is accepted and wfull=1 on that edge.
   - wfull=0 two edges later (3 edges after the rptr change), with wlevel=31.
6. Reset mid-fill: after 10 pushes, pulse wrst for half a cycle -> all outputs return to 0 at once; the next push writes waddr=0.
